// File: rtl/sram_bridge.sv
// ---------------------------------------------------------------------------
// sram_bridge
//
// Turns a single-cycle-style SRAM core port (cpu_en / cpu_wen / cpu_addr)
// into a two-phase address/data bus transaction, and stalls the core until
// the bus has returned the data phase.
//
// Parameters
//   DATA_W  bus and core data width (32 or 64)
//   ADDR_W  byte address width
//   CNT_W   width of the saturating stall-cycle counter
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   cpu_en            core request, held high until cpu_stall is low
//   cpu_wen           byte write enables, all zero = read
//   cpu_addr          byte address
//   cpu_wdata         store data
//   cpu_rdata         load data (always the last latched bus_rdata)
//   cpu_stall         core must hold its request this cycle
//   bus_req           address phase valid (high only in ADDR)
//   bus_wr            write transaction
//   bus_size          log2 of the access size in bytes
//   bus_addr          byte address (optionally translated, see below)
//   bus_wstrb         byte strobes for writes
//   bus_wdata         store data
//   bus_addr_ok       address phase accepted
//   bus_data_ok       data phase complete, bus_rdata valid
//   bus_rdata         load data from the bus
//   stall_cnt         number of cycles cpu_stall has been high (saturating)
//   state_dbg         current FSM state (IDLE=0, ADDR=1, DATA=2, DONE=3)
//
// Optional feature
//   SRAM_BRIDGE_XLATE_EN  when defined, captured addresses in
//                         0x8000_0000-0xBFFF_FFFF leave the bridge with
//                         bits [31:29] cleared (needs ADDR_W = 32).
//
// Handshake semantics
//   The address phase is a valid/ready pair: bus_req is valid, bus_addr_ok
//   is ready, and the phase completes on the first rising edge where both
//   are high. All bus_* request fields come from registers captured at
//   accept time, so they cannot change while bus_req is high. The data
//   phase completes on the first edge with bus_data_ok high after (or in
//   the same cycle as) the address phase; bus_data_ok seen at any other
//   time is ignored.
// ---------------------------------------------------------------------------
module sram_bridge #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 cpu_en,
  input  logic [DATA_W/8-1:0]  cpu_wen,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [DATA_W-1:0]    cpu_wdata,
  output logic [DATA_W-1:0]    cpu_rdata,
  output logic                 cpu_stall,

  output logic                 bus_req,
  output logic                 bus_wr,
  output logic [1:0]           bus_size,
  output logic [ADDR_W-1:0]    bus_addr,
  output logic [DATA_W/8-1:0]  bus_wstrb,
  output logic [DATA_W-1:0]    bus_wdata,
  input  logic                 bus_addr_ok,
  input  logic                 bus_data_ok,
  input  logic [DATA_W-1:0]    bus_rdata,

  output logic [CNT_W-1:0]     stall_cnt,
  output logic [1:0]           state_dbg
);

  localparam int         STRB_W   = DATA_W / 8;
  localparam logic [1:0] SIZE_MAX = 2'($clog2(STRB_W));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;

  // Request registers: the only source of every bus_* request field.
  logic [ADDR_W-1:0]   req_addr;
  logic [STRB_W-1:0]   req_wen;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W-1:0]   rdata_buf;

  logic [3:0]          strb_ones;

  // -------------------------------------------------------------------------
  // FSM and request capture
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_addr  <= '0;
      req_wen   <= '0;
      req_wdata <= '0;
      rdata_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_en) begin
            req_addr  <= cpu_addr;
            req_wen   <= cpu_wen;
            req_wdata <= cpu_wdata;
            state     <= ADDR;
          end
        end
        ADDR: begin
          // bus_data_ok only counts here together with bus_addr_ok; a lone
          // data_ok in the address phase belongs to nobody.
          if (bus_addr_ok) begin
            if (bus_data_ok) begin
              rdata_buf <= bus_rdata;
              state     <= DONE;
            end else begin
              state     <= DATA;
            end
          end
        end
        DATA: begin
          if (bus_data_ok) begin
            rdata_buf <= bus_rdata;
            state     <= DONE;
          end
        end
        DONE: begin
          // cpu_en is still high here because the core only drops it once
          // it sees cpu_stall low; that is the request just completed, so
          // always return to IDLE rather than accepting again.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Saturating stall counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (cpu_stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Core-side outputs
  // -------------------------------------------------------------------------
  always_comb begin
    cpu_stall = 1'b0;
    case (state)
      IDLE:    cpu_stall = cpu_en;
      ADDR:    cpu_stall = 1'b1;
      DATA:    cpu_stall = 1'b1;
      DONE:    cpu_stall = 1'b0;
      default: cpu_stall = 1'b0;
    endcase
  end

  assign cpu_rdata = rdata_buf;
  assign state_dbg = state;

  // -------------------------------------------------------------------------
  // Bus-side outputs, all decoded from state and the request registers
  // -------------------------------------------------------------------------
  assign bus_req   = (state == ADDR);
  assign bus_wr    = |req_wen;
  assign bus_wstrb = req_wen;
  assign bus_wdata = req_wdata;

  // Number of enabled byte lanes decides the access size. Strobe counts that
  // are not a power of two (e.g. three lanes) fall back to a full-width access.
  always_comb begin
    strb_ones = '0;
    for (int i = 0; i < STRB_W; i++) begin
      strb_ones = strb_ones + {3'b000, req_wen[i]};
    end
  end

  always_comb begin
    bus_size = SIZE_MAX;
    if (bus_wr) begin
      case (strb_ones)
        4'd1:    bus_size = 2'd0;
        4'd2:    bus_size = 2'd1;
        4'd4:    bus_size = 2'd2;
        4'd8:    bus_size = 2'd3;
        default: bus_size = SIZE_MAX;
      endcase
    end
  end

`ifdef SRAM_BRIDGE_XLATE_EN
  // kseg1-style window: 0x8000_0000-0xBFFF_FFFF maps onto physical memory by
  // dropping the top three address bits.
  always_comb begin
    bus_addr = req_addr;
    if (req_addr[ADDR_W-1 -: 2] == 2'b10) begin
      bus_addr[ADDR_W-1 -: 3] = 3'b000;
    end
  end
`else
  assign bus_addr = req_addr;
`endif

endmodule

// File: tb/tb_sram_bridge.sv
// ---------------------------------------------------------------------------
// tb_sram_bridge
//
// Directed bench for sram_bridge. A table of transactions (request fields,
// bus handshake delays and the expected bus-side fields) is replayed through
// one driver task; reset-in-flight and counter saturation are hand-written
// sequences. A second instance with CNT_W=4 checks saturation.
// ---------------------------------------------------------------------------
module tb_sram_bridge;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int STRB_W = DATA_W / 8;

`ifdef SRAM_BRIDGE_XLATE_EN
  localparam logic [31:0] KSEG1_BUS_ADDR = 32'h1FC0_0000;
`else
  localparam logic [31:0] KSEG1_BUS_ADDR = 32'hBFC0_0000;
`endif

  // -------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // -------------------------------------------------------------------------
  logic               clk = 1'b0;
  logic               rst;
  logic               cpu_en;
  logic [STRB_W-1:0]  cpu_wen;
  logic [ADDR_W-1:0]  cpu_addr;
  logic [DATA_W-1:0]  cpu_wdata;
  logic [DATA_W-1:0]  cpu_rdata;
  logic               cpu_stall;
  logic               bus_req;
  logic               bus_wr;
  logic [1:0]         bus_size;
  logic [ADDR_W-1:0]  bus_addr;
  logic [STRB_W-1:0]  bus_wstrb;
  logic [DATA_W-1:0]  bus_wdata;
  logic               bus_addr_ok;
  logic               bus_data_ok;
  logic [DATA_W-1:0]  bus_rdata;
  logic [31:0]        stall_cnt;
  logic [1:0]         state_dbg;

  // Saturation instance outputs
  logic [DATA_W-1:0]  s_cpu_rdata;
  logic               s_cpu_stall;
  logic               s_bus_req;
  logic               s_bus_wr;
  logic [1:0]         s_bus_size;
  logic [ADDR_W-1:0]  s_bus_addr;
  logic [STRB_W-1:0]  s_bus_wstrb;
  logic [DATA_W-1:0]  s_bus_wdata;
  logic [3:0]         s_stall_cnt;
  logic [1:0]         s_state_dbg;

  always #5 clk = ~clk;

  sram_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .stall_cnt(stall_cnt), .state_dbg(state_dbg)
  );

  sram_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(s_cpu_rdata), .cpu_stall(s_cpu_stall),
    .bus_req(s_bus_req), .bus_wr(s_bus_wr), .bus_size(s_bus_size),
    .bus_addr(s_bus_addr), .bus_wstrb(s_bus_wstrb), .bus_wdata(s_bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .stall_cnt(s_stall_cnt), .state_dbg(s_state_dbg)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  int n_compared = 0;
  int n_failed   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_stall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Vector table
  // -------------------------------------------------------------------------
  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          a_dly;     // cycles in ADDR before bus_addr_ok
    int          d_dly;     // cycles in DATA before bus_data_ok (0 = same cycle)
    logic        exp_wr;
    logic [1:0]  exp_size;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[7];

  // -------------------------------------------------------------------------
  // Driver: one full transaction, checks on every negedge
  // -------------------------------------------------------------------------
  task automatic run_txn(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);

    @(negedge clk);
    cpu_en    = 1'b1;
    cpu_wen   = v.wen;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    #1;
    check({tag, " accept stall"}, 64'(cpu_stall), 64'd1);
    check({tag, " accept no req"}, 64'(bus_req), 64'd0);

    // Address phase
    for (int i = 0; i <= v.a_dly; i++) begin
      @(negedge clk);
      check({tag, " addr state"}, 64'(state_dbg), 64'd1);
      check({tag, " bus_req"}, 64'(bus_req), 64'd1);
      check({tag, " addr stall"}, 64'(cpu_stall), 64'd1);
      check({tag, " bus_addr"}, 64'(bus_addr), 64'(v.exp_addr));
      check({tag, " bus_wr"}, 64'(bus_wr), 64'(v.exp_wr));
      check({tag, " bus_size"}, 64'(bus_size), 64'(v.exp_size));
      check({tag, " bus_wstrb"}, 64'(bus_wstrb), 64'(v.wen));
      check({tag, " bus_wdata"}, 64'(bus_wdata), 64'(v.wdata));
      if (i == v.a_dly) begin
        bus_addr_ok = 1'b1;
        bus_data_ok = (v.d_dly == 0);
        bus_rdata   = v.rdata;
      end else begin
        // data_ok without addr_ok must not complete anything
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = ~v.rdata;
      end
    end

    // Data phase
    for (int j = 1; j <= v.d_dly; j++) begin
      @(negedge clk);
      check({tag, " data state"}, 64'(state_dbg), 64'd2);
      check({tag, " data no req"}, 64'(bus_req), 64'd0);
      check({tag, " data stall"}, 64'(cpu_stall), 64'd1);
      bus_addr_ok = 1'b0;
      bus_data_ok = (j == v.d_dly);
      bus_rdata   = (j == v.d_dly) ? v.rdata : ~v.rdata;
    end

    // DONE: core still holds cpu_en, acks here are ignored
    @(negedge clk);
    exp_stall = exp_stall + 32'(2 + v.a_dly + v.d_dly);
    check({tag, " done state"}, 64'(state_dbg), 64'd3);
    check({tag, " done stall"}, 64'(cpu_stall), 64'd0);
    check({tag, " done no req"}, 64'(bus_req), 64'd0);
    check({tag, " cpu_rdata"}, 64'(cpu_rdata), 64'(v.rdata));
    check({tag, " stall_cnt"}, 64'(stall_cnt), 64'(exp_stall));
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1;
    bus_rdata   = ~v.rdata;

    // Back in IDLE
    @(negedge clk);
    cpu_en      = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    #1;
    check({tag, " idle state"}, 64'(state_dbg), 64'd0);
    check({tag, " idle stall"}, 64'(cpu_stall), 64'd0);
    check({tag, " idle no req"}, 64'(bus_req), 64'd0);
    check({tag, " rdata held"}, 64'(cpu_rdata), 64'(v.rdata));
  endtask

  // -------------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------------
  initial begin
    vecs[0] = '{4'b0000, 32'h1FC0_0000, 32'h0000_0000, 32'h2408_0001, 0, 0, 1'b0, 2'd2, 32'h1FC0_0000};
    vecs[1] = '{4'b0100, 32'h0000_0102, 32'h00AB_0000, 32'h1111_2222, 3, 0, 1'b1, 2'd0, 32'h0000_0102};
    vecs[2] = '{4'b0000, 32'h0000_0040, 32'h0000_0000, 32'hDEAD_BEEF, 0, 3, 1'b0, 2'd2, 32'h0000_0040};
    vecs[3] = '{4'b1111, 32'h0000_0100, 32'hCAFE_F00D, 32'h0BAD_0BAD, 1, 1, 1'b1, 2'd2, 32'h0000_0100};
    vecs[4] = '{4'b0011, 32'h0000_0204, 32'h0000_5A5A, 32'h1234_5678, 0, 2, 1'b1, 2'd1, 32'h0000_0204};
    vecs[5] = '{4'b0111, 32'h0000_0300, 32'h00C0_FFEE, 32'h8765_4321, 2, 0, 1'b1, 2'd2, 32'h0000_0300};
    vecs[6] = '{4'b0000, 32'hBFC0_0000, 32'h0000_0000, 32'hA5A5_5A5A, 0, 0, 1'b0, 2'd2, KSEG1_BUS_ADDR};

    rst         = 1'b1;
    cpu_en      = 1'b0;
    cpu_wen     = '0;
    cpu_addr    = '0;
    cpu_wdata   = '0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = '0;
    exp_stall   = '0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset state", 64'(state_dbg), 64'd0);
    check("reset bus_req", 64'(bus_req), 64'd0);
    check("reset bus_wr", 64'(bus_wr), 64'd0);
    check("reset bus_wstrb", 64'(bus_wstrb), 64'd0);
    check("reset cpu_rdata", 64'(cpu_rdata), 64'd0);
    check("reset stall_cnt", 64'(stall_cnt), 64'd0);

    for (int k = 0; k < 7; k++) begin
      run_txn(k, vecs[k]);
    end

    // Reset while waiting in DATA; a late data_ok must be ignored
    @(negedge clk);
    cpu_en    = 1'b1;
    cpu_wen   = 4'b1111;
    cpu_addr  = 32'h0000_0200;
    cpu_wdata = 32'h7777_8888;
    @(negedge clk);
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b0;
    @(negedge clk);
    check("rst pre state", 64'(state_dbg), 64'd2);
    bus_addr_ok = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    cpu_en      = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h55AA_55AA;
    exp_stall   = '0;
    #1;
    check("rst state", 64'(state_dbg), 64'd0);
    check("rst bus_req", 64'(bus_req), 64'd0);
    check("rst bus_wr", 64'(bus_wr), 64'd0);
    check("rst bus_wstrb", 64'(bus_wstrb), 64'd0);
    check("rst bus_addr", 64'(bus_addr), 64'd0);
    check("rst cpu_rdata", 64'(cpu_rdata), 64'd0);
    check("rst stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    @(negedge clk);
    bus_data_ok = 1'b0;
    check("late data_ok state", 64'(state_dbg), 64'd0);
    check("late data_ok rdata", 64'(cpu_rdata), 64'd0);

    // Stall counter saturation: request that the bus never accepts
    cpu_en   = 1'b1;
    cpu_wen  = '0;
    cpu_addr = 32'h0000_0400;
    repeat (14) @(negedge clk);
    exp_q.push_back(32'd14);
    exp_q.push_back(32'd14);
    check("sat cnt 14 main", 64'(stall_cnt), 64'(exp_q.pop_front()));
    check("sat cnt 14 small", 64'(s_stall_cnt), 64'(exp_q.pop_front()));
    repeat (6) @(negedge clk);
    exp_q.push_back(32'd20);
    exp_q.push_back(32'd15);
    check("sat cnt 20 main", 64'(stall_cnt), 64'(exp_q.pop_front()));
    check("sat cnt small", 64'(s_stall_cnt), 64'(exp_q.pop_front()));
    check("sat still stalled", 64'(cpu_stall), 64'd1);

    rst    = 1'b1;
    cpu_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("final small cnt", 64'(s_stall_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
